// File: rtl/legv8_main_control.sv
// Multi-cycle LEGv8 main control: sequences FETCH/DECODE/EXECUTE/MEM/WB,
// drives ALUOp for alu_control plus datapath enables, traps illegal opcodes.
module legv8_main_control #(
  parameter int unsigned EXEC_CYCLES = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [10:0]      inst31_21,
  input  logic             mem_ready,
  input  logic             zero,
  output logic             imem_req,
  output logic             ir_write,
  output logic [1:0]       ALUOp,
  output logic             Reg2Loc,
  output logic             ALUSrc,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             pc_write,
  output logic             pc_src,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    C_NONE, C_R, C_I, C_LD, C_ST, C_CBZ, C_B, C_BAD
  } cls_t;

  state_t     state, next_state;
  cls_t       cls;
  logic [1:0] exec_cnt;
  logic       exec_last;

  function automatic cls_t decode(input logic [10:0] op);
    casez (op)
      11'b10001011000,
      11'b11001011000,
      11'b10001010000,
      11'b10101010000: decode = C_R;
      11'b1001000100?: decode = C_I;
      11'b11111000010: decode = C_LD;
      11'b11111000000: decode = C_ST;
      11'b10110100???: decode = C_CBZ;
      11'b000101?????: decode = C_B;
      default:         decode = C_BAD;
    endcase
  endfunction

  assign exec_last = (exec_cnt == 2'(EXEC_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_FETCH;
      cls         <= C_NONE;
      exec_cnt    <= '0;
      instr_count <= '0;
    end else begin
      state <= next_state;
      if (state == S_FETCH && mem_ready)
        cls <= decode(inst31_21);
      if (state == S_EXEC && !exec_last)
        exec_cnt <= exec_cnt + 2'd1;
      else
        exec_cnt <= '0;
      if (pc_write)
        instr_count <= instr_count + 1'b1;
    end
  end

  assign illegal = (state == S_TRAP);

  always_comb begin
    next_state = state;
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    ALUOp      = 2'b00;
    Reg2Loc    = 1'b0;
    ALUSrc     = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    unique case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        // gated by reset_n so the load pulse stays low while reset is held
        ir_write = mem_ready && reset_n;
        if (mem_ready) next_state = S_DECODE;
      end
      S_DECODE: begin
        next_state = (cls == C_BAD) ? S_TRAP : S_EXEC;
      end
      S_EXEC: begin
        ALUOp   = (cls == C_R) ? 2'b10 : (cls == C_CBZ) ? 2'b01 : 2'b00;
        ALUSrc  = (cls == C_I) || (cls == C_LD) || (cls == C_ST);
        Reg2Loc = (cls == C_ST) || (cls == C_CBZ);
        if (exec_last) begin
          unique case (cls)
            C_R, C_I:   next_state = S_WB;
            C_LD, C_ST: next_state = S_MEM;
            C_CBZ: begin
              pc_write   = 1'b1;
              pc_src     = zero;
              next_state = S_FETCH;
            end
            C_B: begin
              pc_write   = 1'b1;
              pc_src     = 1'b1;
              next_state = S_FETCH;
            end
            default: next_state = S_TRAP;
          endcase
        end
      end
      S_MEM: begin
        ALUSrc   = 1'b1;
        Reg2Loc  = (cls == C_ST);
        MemRead  = (cls == C_LD);
        MemWrite = (cls == C_ST);
        if (mem_ready) begin
          if (cls == C_ST) begin
            pc_write   = 1'b1;
            next_state = S_FETCH;
          end else begin
            next_state = S_WB;
          end
        end
      end
      S_WB: begin
        RegWrite   = 1'b1;
        MemtoReg   = (cls == C_LD);
        pc_write   = 1'b1;
        next_state = S_FETCH;
      end
      S_TRAP: next_state = S_TRAP;
      default: next_state = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_legv8_main_control.sv
// Directed bench for legv8_main_control: expected control vectors go through
// a scoreboard queue and are checked mid-cycle against both DUT instances.
module tb_legv8_main_control;

  // {imem_req, ir_write, ALUOp[1:0], Reg2Loc, ALUSrc, MemRead, MemWrite,
  //  MemtoReg, RegWrite, pc_write, pc_src, illegal}
  localparam logic [12:0] E_IDLE    = 13'b1_0_00_0_0_0_0_0_0_0_0_0;
  localparam logic [12:0] E_FET     = 13'b1_1_00_0_0_0_0_0_0_0_0_0;
  localparam logic [12:0] E_DEC     = 13'b0_0_00_0_0_0_0_0_0_0_0_0;
  localparam logic [12:0] E_EX_R    = 13'b0_0_10_0_0_0_0_0_0_0_0_0;
  localparam logic [12:0] E_EX_I    = 13'b0_0_00_0_1_0_0_0_0_0_0_0;
  localparam logic [12:0] E_EX_ST   = 13'b0_0_00_1_1_0_0_0_0_0_0_0;
  localparam logic [12:0] E_EX_CBZ1 = 13'b0_0_01_1_0_0_0_0_0_1_1_0;
  localparam logic [12:0] E_EX_CBZ0 = 13'b0_0_01_1_0_0_0_0_0_1_0_0;
  localparam logic [12:0] E_EX_B    = 13'b0_0_00_0_0_0_0_0_0_1_1_0;
  localparam logic [12:0] E_MEM_LD  = 13'b0_0_00_0_1_1_0_0_0_0_0_0;
  localparam logic [12:0] E_MEM_ST  = 13'b0_0_00_1_1_0_1_0_0_0_0_0;
  localparam logic [12:0] E_MEM_STD = 13'b0_0_00_1_1_0_1_0_0_1_0_0;
  localparam logic [12:0] E_WB_R    = 13'b0_0_00_0_0_0_0_0_1_1_0_0;
  localparam logic [12:0] E_WB_LD   = 13'b0_0_00_0_0_0_0_1_1_1_0_0;
  localparam logic [12:0] E_TRAP    = 13'b0_0_00_0_0_0_0_0_0_0_0_1;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_ADDI = 11'b10010001001;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100101;
  localparam logic [10:0] OP_B    = 11'b00010110011;
  localparam logic [10:0] OP_BAD  = 11'b11111111111;

  typedef struct {
    string       tag;
    logic [12:0] ctl;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n, mem_ready, zero;
  logic [10:0] inst31_21;
  logic        imem_req, ir_write, Reg2Loc, ALUSrc, MemRead, MemWrite;
  logic        MemtoReg, RegWrite, pc_write, pc_src, illegal;
  logic [1:0]  ALUOp;
  logic [15:0] instr_count;

  logic        reset2_n;
  logic        imem_req2, ir_write2, Reg2Loc2, ALUSrc2, MemRead2, MemWrite2;
  logic        MemtoReg2, RegWrite2, pc_write2, pc_src2, illegal2;
  logic [1:0]  ALUOp2;
  logic [3:0]  instr_count2;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] ecnt = '0;
  logic [3:0]  ecnt2 = '0;

  always #5 clk = ~clk;

  legv8_main_control dut (
    .clk(clk), .reset_n(reset_n), .inst31_21(inst31_21),
    .mem_ready(mem_ready), .zero(zero), .imem_req(imem_req),
    .ir_write(ir_write), .ALUOp(ALUOp), .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .pc_write(pc_write), .pc_src(pc_src),
    .illegal(illegal), .instr_count(instr_count)
  );

  // narrow counter and multi-cycle EXECUTE to reach wrap and stretch paths
  legv8_main_control #(.EXEC_CYCLES(3), .CNT_W(4)) dut2 (
    .clk(clk), .reset_n(reset2_n), .inst31_21(OP_B),
    .mem_ready(1'b1), .zero(1'b0), .imem_req(imem_req2),
    .ir_write(ir_write2), .ALUOp(ALUOp2), .Reg2Loc(Reg2Loc2), .ALUSrc(ALUSrc2),
    .MemRead(MemRead2), .MemWrite(MemWrite2), .MemtoReg(MemtoReg2),
    .RegWrite(RegWrite2), .pc_write(pc_write2), .pc_src(pc_src2),
    .illegal(illegal2), .instr_count(instr_count2)
  );

  task automatic check(input exp_t e, input logic [12:0] octl,
                       input logic [15:0] ocnt);
    vectors++;
    assert (octl === e.ctl) else begin
      miscompares++;
      $error("FAIL %s ctl observed=%b expected=%b", e.tag, octl, e.ctl);
    end
    vectors++;
    assert (ocnt === e.cnt) else begin
      miscompares++;
      $error("FAIL %s count observed=%0h expected=%0h", e.tag, ocnt, e.cnt);
    end
  endtask

  task automatic cyc(input string tag, input logic rst, input logic [10:0] op,
                     input logic mr, input logic z, input logic [12:0] ectl);
    exp_t e;
    @(negedge clk);
    reset_n = rst; inst31_21 = op; mem_ready = mr; zero = z;
    if (!rst) ecnt = '0;
    sb.push_back('{tag, ectl, ecnt});
    if (ectl[2]) ecnt = ecnt + 16'd1;
    #2;
    e = sb.pop_front();
    check(e, {imem_req, ir_write, ALUOp, Reg2Loc, ALUSrc, MemRead, MemWrite,
              MemtoReg, RegWrite, pc_write, pc_src, illegal}, instr_count);
  endtask

  task automatic cyc2(input string tag, input logic [12:0] ectl);
    exp_t e;
    @(negedge clk);
    reset2_n = 1'b1;
    sb.push_back('{tag, ectl, {12'd0, ecnt2}});
    if (ectl[2]) ecnt2 = ecnt2 + 4'd1;
    #2;
    e = sb.pop_front();
    check(e, {imem_req2, ir_write2, ALUOp2, Reg2Loc2, ALUSrc2, MemRead2,
              MemWrite2, MemtoReg2, RegWrite2, pc_write2, pc_src2, illegal2},
          {12'd0, instr_count2});
  endtask

  initial begin
    reset_n = 1'b0; reset2_n = 1'b0;
    inst31_21 = OP_ADD; mem_ready = 1'b1; zero = 1'b0;

    cyc("reset",      1'b0, OP_ADD, 1'b1, 1'b0, E_IDLE);
    cyc("add_fetch",  1'b1, OP_ADD, 1'b1, 1'b0, E_FET);
    cyc("add_dec",    1'b1, OP_BAD, 1'b1, 1'b0, E_DEC);
    cyc("add_ex",     1'b1, OP_BAD, 1'b1, 1'b0, E_EX_R);
    cyc("add_wb",     1'b1, OP_BAD, 1'b1, 1'b0, E_WB_R);

    cyc("ld_fetch",   1'b1, OP_LDUR, 1'b1, 1'b0, E_FET);
    cyc("ld_dec",     1'b1, OP_ADD,  1'b0, 1'b0, E_DEC);
    cyc("ld_ex",      1'b1, OP_ADD,  1'b1, 1'b0, E_EX_I);
    for (int unsigned i = 0; i < 3; i++)
      cyc("ld_mem_wait", 1'b1, OP_ADD, 1'b0, 1'b0, E_MEM_LD);
    cyc("ld_mem_done", 1'b1, OP_ADD, 1'b1, 1'b0, E_MEM_LD);
    cyc("ld_wb",      1'b1, OP_ADD,  1'b0, 1'b0, E_WB_LD);

    cyc("st_fetch",   1'b1, OP_STUR, 1'b1, 1'b0, E_FET);
    cyc("st_dec",     1'b1, OP_ADD,  1'b1, 1'b0, E_DEC);
    cyc("st_ex",      1'b1, OP_ADD,  1'b1, 1'b0, E_EX_ST);
    cyc("st_mem",     1'b1, OP_ADD,  1'b1, 1'b0, E_MEM_STD);

    cyc("cbz1_fetch", 1'b1, OP_CBZ,  1'b1, 1'b0, E_FET);
    cyc("cbz1_dec",   1'b1, OP_ADD,  1'b1, 1'b0, E_DEC);
    cyc("cbz1_ex",    1'b1, OP_ADD,  1'b1, 1'b1, E_EX_CBZ1);
    cyc("cbz0_fetch", 1'b1, OP_CBZ,  1'b1, 1'b1, E_FET);
    cyc("cbz0_dec",   1'b1, OP_ADD,  1'b1, 1'b1, E_DEC);
    cyc("cbz0_ex",    1'b1, OP_ADD,  1'b1, 1'b0, E_EX_CBZ0);

    cyc("addi_fetch", 1'b1, OP_ADDI, 1'b1, 1'b0, E_FET);
    cyc("addi_dec",   1'b1, OP_ADD,  1'b1, 1'b0, E_DEC);
    cyc("addi_ex",    1'b1, OP_ADD,  1'b1, 1'b0, E_EX_I);
    cyc("addi_wb",    1'b1, OP_ADD,  1'b1, 1'b0, E_WB_R);

    cyc("b_wait",     1'b1, OP_BAD,  1'b0, 1'b0, E_IDLE);
    cyc("b_wait",     1'b1, OP_BAD,  1'b0, 1'b0, E_IDLE);
    cyc("b_fetch",    1'b1, OP_B,    1'b1, 1'b0, E_FET);
    cyc("b_dec",      1'b1, OP_BAD,  1'b1, 1'b0, E_DEC);
    cyc("b_ex",       1'b1, OP_BAD,  1'b1, 1'b0, E_EX_B);

    cyc("st2_fetch",  1'b1, OP_STUR, 1'b1, 1'b0, E_FET);
    cyc("st2_dec",    1'b1, OP_ADD,  1'b1, 1'b0, E_DEC);
    cyc("st2_ex",     1'b1, OP_ADD,  1'b0, 1'b0, E_EX_ST);
    cyc("st2_wait",   1'b1, OP_ADD,  1'b0, 1'b0, E_MEM_ST);
    cyc("st2_rst",    1'b0, OP_ADD,  1'b1, 1'b0, E_IDLE);
    cyc("st2_refetch", 1'b1, OP_ADD, 1'b1, 1'b0, E_FET);
    cyc("st2_dec2",   1'b1, OP_ADD,  1'b1, 1'b0, E_DEC);
    cyc("st2_ex2",    1'b1, OP_ADD,  1'b1, 1'b0, E_EX_R);
    cyc("st2_wb2",    1'b1, OP_ADD,  1'b1, 1'b0, E_WB_R);

    cyc("bad_fetch",  1'b1, OP_BAD,  1'b1, 1'b0, E_FET);
    cyc("bad_dec",    1'b1, OP_ADD,  1'b1, 1'b0, E_DEC);
    for (int unsigned i = 0; i < 20; i++)
      cyc("trap_hold", 1'b1, OP_ADD, 1'(i[0]), 1'b0, E_TRAP);
    cyc("trap_rst",   1'b0, OP_ADD,  1'b1, 1'b0, E_IDLE);
    cyc("trap_refetch", 1'b1, OP_ADD, 1'b1, 1'b0, E_FET);

    // 16 B retirements on a 4-bit counter, EXECUTE stretched to 3 cycles
    for (int unsigned n = 0; n < 16; n++) begin
      cyc2("w_fetch", E_FET);
      cyc2("w_dec",   E_DEC);
      cyc2("w_ex1",   E_DEC);
      cyc2("w_ex2",   E_DEC);
      cyc2("w_ex3",   E_EX_B);
    end
    cyc2("w_wrapped", E_FET);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
